// File: rtl/mux_arb_pkg.sv
// Shared types and sizing for the round-robin arbiter that fronts the 4:1 mux.
// Keeps the requester count, select width and tenure counter width in one place.
package mux_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int HOLD_W  = 4;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux.sv
// The team's shared 4:1 single-bit mux; {s1,s0} selects which input drives y.
module mux (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic s1,
    input  logic s0,
    output logic y
);

    always_comb begin
        case ({s1, s0})
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            default: y = i3;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Rotating priority pick: the first requester at or after ptr (mod NUM_REQ) wins.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Walking from the farthest offset back towards ptr lets the nearest hit overwrite the rest.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux select: bounded tenure, back-to-back
// handover, and a registered copy of the selected input.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               i0,
    input  logic               i1,
    input  logic               i2,
    input  logic               i3,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s1,
    output logic               s0,
    output logic               out,
    output logic               busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   owner;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [NUM_REQ-1:0] din;
    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               release_now;

    assign din         = {i3, i2, i1, i0};
    assign release_now = !req[owner] || (hold_cnt == HOLD_LAST);

    // On release the pointer moves past the owner this same cycle, so the re-pick already sees it.
    assign pick_ptr = (state == GRANT) ? owner + SEL_W'(1) : ptr;

    rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Select lines only change on a new grant, so they keep the last owner while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            s1       <= 1'b0;
            s0       <= 1'b0;
            busy     <= 1'b0;
            out      <= 1'b0;
        end else begin
            out <= (gnt != '0) ? din[{s1, s0}] : 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= GRANT;
                        owner      <= pick_idx;
                        gnt        <= onehot(pick_idx);
                        {s1, s0}   <= pick_idx;
                        hold_cnt   <= '0;
                        busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!release_now) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        ptr <= owner + SEL_W'(1);
                        if (pick_any) begin
                            owner    <= pick_idx;
                            gnt      <= onehot(pick_idx);
                            {s1, s0} <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table plus hand-built tenure,
// release, re-grant, reset and rotation sequences, scored through a queue.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] din;

    logic [3:0] gnt8, gnt4;
    logic       s1_8, s0_8, out8, busy8;
    logic       s1_4, s0_4, out4, busy4;
    logic       use4;
    logic [1:0] msel;
    logic       mux_y;

    always #5 clock = ~clock;

    mux_rr_arbiter #(.MAX_HOLD(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .gnt(gnt8), .s1(s1_8), .s0(s0_8), .out(out8), .busy(busy8)
    );

    mux_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .gnt(gnt4), .s1(s1_4), .s0(s0_4), .out(out4), .busy(busy4)
    );

    assign msel = use4 ? {s1_4, s0_4} : {s1_8, s0_8};

    mux u_mux (
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .s1(msel[1]), .s0(msel[0]), .y(mux_y)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       out;
        logic [3:0] din;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[13];
    int         passed = 0;
    int         total  = 0;
    logic [3:0] last_gnt;
    logic [1:0] last_sel;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [3:0] g;
        logic [1:0] s;
        logic       b, o;
        if (sb.size() == 0) begin
            total++;
            $display("[TB] FAIL scoreboard: got empty queue, expected one entry");
            return;
        end
        e = sb.pop_front();
        g = use4 ? gnt4 : gnt8;
        s = use4 ? {s1_4, s0_4} : {s1_8, s0_8};
        b = use4 ? busy4 : busy8;
        o = use4 ? out4 : out8;
        check("gnt",  8'(g), 8'(e.gnt));
        check("sel",  8'(s), 8'(e.sel));
        check("busy", 8'(b), 8'(e.busy));
        check("out",  8'(o), 8'(e.out));
        check("mux",  8'(mux_y), 8'(e.din[e.sel]));
    endtask

    // Drives one cycle of inputs, queues what should appear after the edge, then scores it.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                                 input logic [3:0] g, input logic [1:0] s, input logic b);
        exp_t e;
        req    = r;
        din    = d;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        e.din  = d;
        e.out  = (last_gnt != 4'b0) ? d[last_sel] : 1'b0;
        last_gnt = g;
        last_sel = s;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        req     = 4'b0;
        din     = 4'b0;
        #1;
        check("rst_gnt8", 8'(gnt8), 8'h0);
        check("rst_sel8", 8'({s1_8, s0_8}), 8'h0);
        check("rst_out8", 8'(out8), 8'h0);
        check("rst_busy8", 8'(busy8), 8'h0);
        check("rst_gnt4", 8'(gnt4), 8'h0);
        @(negedge clock);
        reset_n  = 1'b1;
        last_gnt = 4'b0;
        last_sel = 2'd0;
    endtask

    initial begin
        use4     = 1'b0;
        reset_n  = 1'b1;
        req      = 4'b0;
        din      = 4'b0;
        last_gnt = 4'b0;
        last_sel = 2'd0;

        vt[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[3]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0};
        vt[4]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vt[5]  = '{4'b1001, 4'b1011, 4'b1000, 2'd3, 1'b1};
        vt[6]  = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vt[7]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1};
        vt[8]  = '{4'b0011, 4'b0110, 4'b0001, 2'd0, 1'b1};
        vt[9]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1};
        vt[10] = '{4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0};
        vt[11] = '{4'b1010, 4'b0101, 4'b1000, 2'd3, 1'b1};
        vt[12] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0};

        @(negedge clock);
        doReset();

        for (int v = 0; v < 13; v++)
            applyStimulus(vt[v].req, vt[v].din, vt[v].gnt, vt[v].sel, vt[v].busy);

        // Tenure limit: two steady requesters hand over every 8 cycles with no gap.
        for (int k = 0; k < 18; k++) begin
            if (((k / 8) % 2) == 0) applyStimulus(4'b0011, 4'(k), 4'b0001, 2'd0, 1'b1);
            else                    applyStimulus(4'b0011, 4'(k), 4'b0010, 2'd1, 1'b1);
        end
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0);

        // Early release by owner 1; picking 3 over 0 shows the pointer moved to 2.
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1);
        applyStimulus(4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0);

        // Lone requester is re-granted across tenure expiry without busy dropping.
        for (int k = 0; k < 20; k++)
            applyStimulus(4'b0001, {3'b0, k[0]}, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0);

        // Reset mid-grant with owner 2 at hold_cnt 3.
        for (int k = 0; k < 4; k++)
            applyStimulus(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_gnt", 8'(gnt8), 8'h0);
        check("midrst_s1", 8'(s1_8), 8'h0);
        check("midrst_s0", 8'(s0_8), 8'h0);
        check("midrst_out", 8'(out8), 8'h0);
        check("midrst_busy", 8'(busy8), 8'h0);
        reset_n  = 1'b1;
        last_gnt = 4'b0;
        last_sel = 2'd0;
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0);

        // Rotation fairness on the MAX_HOLD=4 instance.
        @(negedge clock);
        doReset();
        use4 = 1'b1;
        for (int k = 0; k < 64; k++)
            applyStimulus(4'b1111, 4'($urandom_range(0, 15)),
                          4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1);
        applyStimulus(4'b0000, 4'b0110, 4'b0000, 2'd3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
